demultiplexor_1a6_16bits_reg: RTL and testbench
===============================================

# demultiplexor_1a6_16bits_reg

Registered 1-to-6 demultiplexer with valid/ready handshakes. It takes one 16-bit input stream and steers each word to one of six output lanes selected by a 3-bit lane field. Each lane has a one-word holding register, so a stalled lane does not block traffic to other lanes once its register drains. It is the distributing end of the 6-to-1 16-bit selection path: it fans a shared bus back out to six consumers.

## Interface
- WIDTH, 16, data width of the input and of every output lane
- DROP_W, 8, width of the dropped-word counter
- CLK  input  1  single clock, all state changes on its rising edge
- RST_N  input  1  asynchronous reset, active-low; clears all state immediately
- IN  input  WIDTH  input data word
- SEL  input  3  destination lane: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F; 6 and 7 are invalid
- IN_VALID  input  1  IN/SEL carry a word this cycle
- IN_READY  output  1  block accepts the word this cycle
- OUT_A … OUT_F  output  WIDTH each  lane holding registers
- OUT_VALID  output  6  bit n set means lane n holds an undelivered word (bit 0=A … bit 5=F)
- OUT_READY  input  6  bit n set means the lane n consumer takes the word this cycle
- DROP_CNT  output  DROP_W  count of words dropped because SEL was invalid
- CLR_DROP  input  1  synchronous clear of DROP_CNT

## Operation
- Transfer in: IN_VALID & IN_READY at a rising edge.
- Transfer out on lane n: OUT_VALID[n] & OUT_READY[n] at a rising edge.
- IN_READY is combinational and does not depend on IN_VALID:
  - 1 when SEL > 5;
  - otherwise ~OUT_VALID[SEL] | OUT_READY[SEL].
- Accepted word with SEL = n ≤ 5: register OUT_n ← IN, and OUT_VALID[n] ← 1.
- Accepted word with SEL > 5: word discarded, no lane changes, DROP_CNT increments. DROP_CNT saturates at 2^DROP_W−1.
- Transfer out on lane n with no new word for lane n in the same cycle: OUT_VALID[n] ← 0. OUT_n keeps its last value; it is not cleared.
- Simultaneous transfer out and transfer in on the same lane: OUT_VALID[n] stays 1 and OUT_n takes the new word. No bubble, no loss.
- Lanes are independent. Any number of lanes may drain in the same cycle. At most one lane loads per cycle.
- While OUT_VALID[n] = 1 and OUT_READY[n] = 0, OUT_n stays stable. OUT_VALID[n] never falls without a transfer out.
- CLR_DROP = 1 forces DROP_CNT to 0 on the next edge. This takes priority over a simultaneous increment.
- Reset (RST_N = 0, at any time, including mid-transfer):
  - OUT_A … OUT_F = 0, OUT_VALID = 0, DROP_CNT = 0;
  - held words are lost;
  - IN_READY then follows the combinational rule with all lanes empty, so it is 1.

## Timing
- Latency: a word accepted at edge k is visible on OUT_n with OUT_VALID[n] = 1 after edge k, and can be consumed at edge k+1.
- Throughput: one word per cycle into a lane whose consumer holds OUT_READY[n] = 1 continuously.
- A lane with OUT_READY[n] held at 0: one word is held, and further words to lane n see IN_READY = 0.
- Combinational paths: only SEL/OUT_READY → IN_READY. Every other output comes straight from a register.
- DROP_CNT updates one edge after the dropped transfer.
- Reset release: the first edge with RST_N = 1 may already accept a word.

## Test plan
- Reset, then IN=16'h1234, SEL=2, IN_VALID=1 for one cycle, OUT_READY=0 → OUT_C=16'h1234 and OUT_VALID=6'b000100 after one edge. Other OUT_x stay 0.
- Lane C stalled (OUT_READY[2]=0), send SEL=2, IN=16'hBEEF → IN_READY=0, OUT_C stays 16'h1234. Then send SEL=0, IN=16'h00AA → accepted, OUT_A=16'h00AA, OUT_VALID=6'b000101.
- Lane C holding 16'h1234, assert OUT_READY[2]=1 with IN=16'h5678, SEL=2 in the same cycle → IN_READY=1, OUT_C=16'h5678, OUT_VALID[2] stays 1.
- Send 300 words with SEL=7 → IN_READY=1 throughout, lanes unchanged, DROP_CNT=255. Pulse CLR_DROP together with one more SEL=6 word → DROP_CNT=0.
- Stream 6 words SEL=0..5 with IN=16'h0010+SEL, all OUT_READY=0 → OUT_VALID=6'b111111 and each lane holds its value. Drain all lanes at once with OUT_READY=6'b111111 → OUT_VALID=0 after one edge.
- With lanes A and D full, drop RST_N mid-cycle (asynchronously) → OUT_VALID=0, all OUT_x=0 and DROP_CNT=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demultiplexor_1a6_16bits_reg.sv
// Purpose: registered 1-to-6 demultiplexer; steers each input word to one of six lane holding registers by sel_i.
// Latency: one cycle from input transfer to out_valid_o[n]; lane can be consumed at the following edge.
// Backpressure: in_ready_o drops only when the addressed lane is full and its consumer is not taking it this cycle; invalid lanes always accept (and drop).
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_n_i        asynchronous active-low reset, clears all state
//   in_i, sel_i    input word and destination lane (0..5 valid, 6/7 dropped)
//   in_valid_i     input word present
//   in_ready_o     input accepted this cycle (combinational from sel_i/out_ready_i)
//   out_a_o..out_f_o  lane holding registers
//   out_valid_o    per-lane "holds an undelivered word"
//   out_ready_i    per-lane consumer ready
//   drop_cnt_o     saturating count of words dropped for an invalid lane
//   clr_drop_i     synchronous clear of drop_cnt_o (wins over increment)
module demultiplexor_1a6_16bits_reg #(
    parameter int WIDTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [WIDTH-1:0]  in_i,
    input  logic [2:0]        sel_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [WIDTH-1:0]  out_a_o,
    output logic [WIDTH-1:0]  out_b_o,
    output logic [WIDTH-1:0]  out_c_o,
    output logic [WIDTH-1:0]  out_d_o,
    output logic [WIDTH-1:0]  out_e_o,
    output logic [WIDTH-1:0]  out_f_o,
    output logic [5:0]        out_valid_o,
    input  logic [5:0]        out_ready_i,
    output logic [DROP_W-1:0] drop_cnt_o,
    input  logic              clr_drop_i
);

    localparam logic [2:0]        LAST_LANE = 3'd5;
    localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

    logic [WIDTH-1:0]  data_q [6];
    logic [WIDTH-1:0]  data_d [6];
    logic [5:0]        vld_q;
    logic [5:0]        vld_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    logic sel_bad;
    logic accept;
    logic load;
    logic drop;

    // Padded to 8 bits so sel_i can index them without an out-of-range read;
    // the padding entries are never used because sel_bad short-circuits them.
    logic [7:0] vld_ext;
    logic [7:0] rdy_ext;

    assign vld_ext = {2'b00, vld_q};
    assign rdy_ext = {2'b00, out_ready_i};

    assign sel_bad    = (sel_i > LAST_LANE);
    // A full lane can still accept when its consumer drains it in the same cycle.
    assign in_ready_o = sel_bad | ~vld_ext[sel_i] | rdy_ext[sel_i];
    assign accept     = in_valid_i & in_ready_o;
    assign load       = accept & ~sel_bad;
    assign drop       = accept &  sel_bad;

    always_comb begin
        for (int n = 0; n < 6; n++) begin
            data_d[n] = data_q[n];
            // Drain first, then a same-cycle load re-sets the valid bit: no bubble.
            vld_d[n]  = vld_q[n] & ~out_ready_i[n];
            if (load && (sel_i == 3'(n))) begin
                data_d[n] = in_i;
                vld_d[n]  = 1'b1;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (clr_drop_i) begin
            drop_d = '0;
        end else if (drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < 6; n++) begin
                data_q[n] <= '0;
            end
            vld_q  <= '0;
            drop_q <= '0;
        end else begin
            for (int n = 0; n < 6; n++) begin
                data_q[n] <= data_d[n];
            end
            vld_q  <= vld_d;
            drop_q <= drop_d;
        end
    end

    assign out_a_o     = data_q[0];
    assign out_b_o     = data_q[1];
    assign out_c_o     = data_q[2];
    assign out_d_o     = data_q[3];
    assign out_e_o     = data_q[4];
    assign out_f_o     = data_q[5];
    assign out_valid_o = vld_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_demultiplexor_1a6_16bits_reg.sv
// Purpose: self-checking bench for demultiplexor_1a6_16bits_reg against a lane-occupancy model.
// Latency: checks in_ready before each edge and all registered outputs 1ns after it.
// Backpressure: random per-lane consumer readiness exercises full/drain/same-cycle reload.
module tb_demultiplexor_1a6_16bits_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready;
    logic [7:0]  drop_cnt;
    logic        clr_drop;

    always #5 clk = ~clk;

    demultiplexor_1a6_16bits_reg #(.WIDTH(16), .DROP_W(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_i        (din),
        .sel_i       (sel),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .out_c_o     (out_c),
        .out_d_o     (out_d),
        .out_e_o     (out_e),
        .out_f_o     (out_f),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .drop_cnt_o  (drop_cnt),
        .clr_drop_i  (clr_drop)
    );

    logic [15:0] lane_o [6];
    assign lane_o[0] = out_a;
    assign lane_o[1] = out_b;
    assign lane_o[2] = out_c;
    assign lane_o[3] = out_d;
    assign lane_o[4] = out_e;
    assign lane_o[5] = out_f;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each lane is a one-entry slot (value + occupied flag).
    logic [15:0] m_data [6];
    bit          m_full [6];
    int          m_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 6; n++) begin
            m_data[n] = 16'h0;
            m_full[n] = 1'b0;
        end
        m_drop = 0;
    endtask

    function automatic bit model_ready(input int s, input logic [5:0] r);
        if (s > 5) return 1'b1;
        return !m_full[s] || r[s];
    endfunction

    function automatic logic [5:0] model_valid();
        logic [5:0] v;
        for (int n = 0; n < 6; n++) v[n] = m_full[n];
        return v;
    endfunction

    task automatic check_outs();
        check_eq("out_valid", 32'(out_valid), 32'(model_valid()));
        for (int n = 0; n < 6; n++) begin
            check_eq($sformatf("lane%0d", n), 32'(lane_o[n]), 32'(m_data[n]));
        end
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
    task automatic cycle(input int s, input logic [15:0] d, input bit v,
                         input logic [5:0] r, input bit c);
        bit rdy;
        sel       = 3'(s);
        din       = d;
        in_valid  = v;
        out_ready = r;
        clr_drop  = c;
        #1;
        rdy = model_ready(s, r);
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        for (int n = 0; n < 6; n++) begin
            if (m_full[n] && r[n]) m_full[n] = 1'b0;
        end
        if (v && rdy) begin
            if (s <= 5) begin
                m_data[s] = d;
                m_full[s] = 1'b1;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        if (c) m_drop = 0;
        #1;
        check_outs();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; din = '0; sel = '0; in_valid = 1'b0; out_ready = '0; clr_drop = 1'b0;
        model_reset();
        #12;
        check_outs();
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word to lane C.
        cycle(2, 16'h1234, 1, 6'b000000, 0);
        check_eq("t1_out_c", 32'(out_c), 32'h1234);
        check_eq("t1_valid", 32'(out_valid), 32'b000100);

        // Stalled lane C refuses; lane A still accepts.
        cycle(2, 16'hBEEF, 1, 6'b000000, 0);
        check_eq("t2_out_c_held", 32'(out_c), 32'h1234);
        cycle(0, 16'h00AA, 1, 6'b000000, 0);
        check_eq("t2_out_a", 32'(out_a), 32'h00AA);
        check_eq("t2_valid", 32'(out_valid), 32'b000101);

        // Same-cycle drain and reload on lane C.
        cycle(2, 16'h5678, 1, 6'b000100, 0);
        check_eq("t3_out_c", 32'(out_c), 32'h5678);
        check_eq("t3_valid", 32'(out_valid), 32'b000101);

        // Saturating drop counter, then clear beats a simultaneous drop.
        for (int i = 0; i < 300; i++) cycle(7, 16'($urandom), 1, 6'b000000, 0);
        check_eq("t4_drop_sat", 32'(drop_cnt), 32'd255);
        check_eq("t4_lane_c", 32'(out_c), 32'h5678);
        cycle(6, 16'h0F0F, 1, 6'b000000, 1);
        check_eq("t4_drop_clr", 32'(drop_cnt), 32'd0);

        // Fill all six lanes, then drain together.
        cycle(0, 16'h0000, 0, 6'b111111, 0);
        for (int s = 0; s < 6; s++) cycle(s, 16'(16'h0010 + s), 1, 6'b000000, 0);
        check_eq("t5_all_full", 32'(out_valid), 32'b111111);
        check_eq("t5_out_f", 32'(out_f), 32'h0015);
        cycle(0, 16'h0000, 0, 6'b111111, 0);
        check_eq("t5_all_empty", 32'(out_valid), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(int'($urandom_range(0, 7)), 16'($urandom), bit'($urandom_range(0, 3) != 0),
                  6'($urandom), bit'($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset mid-cycle with lanes A and D full and a nonzero drop count.
        cycle(0, 16'hA5A5, 1, 6'b000000, 0);
        cycle(3, 16'hD00D, 1, 6'b000000, 0);
        cycle(7, 16'h1111, 1, 6'b000000, 0);
        check_eq("t6_pre_valid", 32'(out_valid[0] & out_valid[3]), 32'd1);
        sel = 3'd0; in_valid = 1'b0; out_ready = 6'b000000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First edge after release already accepts.
        cycle(4, 16'hCAFE, 1, 6'b000000, 0);
        check_eq("t6_out_e", 32'(out_e), 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
